pc_sequencer: RTL

//  FSM that sequences the program counter each instruction: drives its reset, halt, branch
//  and offset inputs. Waits out instruction-memory latency, applies decoder results
//  (branch/halt/call/return) for one cycle, then stops in HALTED.

---
 rtl/pc_sequencer_if.sv | 34 +++
 rtl/pc_sequencer.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer_if.sv
// PC sequencer bus: decoder/start inputs and PC control outputs.
// master drives start and decoder results; slave is the sequencer.
interface pc_sequencer_if;
  logic        start;
  logic [7:0]  pc_addr;
  logic        is_halt;
  logic        is_branch;
  logic        cond_flag;
  logic        is_call;
  logic        is_ret;
  logic [7:0]  br_offset;
  logic        pc_reset;
  logic        pc_halt;
  logic        pc_branch;
  logic [7:0]  pc_offset;
  logic [1:0]  state;
  logic        done;
  logic        err;
  logic [15:0] icount;

  modport master (
    output start, pc_addr, is_halt, is_branch,
    output cond_flag, is_call, is_ret, br_offset,
    input  pc_reset, pc_halt, pc_branch, pc_offset,
    input  state, done, err, icount
  );

  modport slave (
    input  start, pc_addr, is_halt, is_branch,
    input  cond_flag, is_call, is_ret, br_offset,
    output pc_reset, pc_halt, pc_branch, pc_offset,
    output state, done, err, icount
  );
endinterface

// File: rtl/pc_sequencer.sv
// Program-counter sequencer FSM: IDLE -> FETCH (memory wait) -> EXEC -> HALTED.
// Optional return-address stack enabled by defining PC_CALL_STACK_EN.
module pc_sequencer #(
  parameter int MEM_LAT     = 1,
  parameter int STACK_DEPTH = 4
) (
  input logic           clk,
  input logic           reset,
  pc_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    EXEC   = 2'd2,
    HALTED = 2'd3
  } state_t;

  localparam int CW = (MEM_LAT < 2) ? 1 : $clog2(MEM_LAT + 1);
  localparam logic [CW-1:0] LOAD =
    (MEM_LAT <= 1) ? '0 : CW'(MEM_LAT - 1);

  if (STACK_DEPTH < 1 || STACK_DEPTH > 16) begin : g_bad_depth
    $error("STACK_DEPTH must be within 1..16");
  end

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [15:0]    ic_q, ic_d;
  logic           halt_x;
  logic           br;
  logic [7:0]     off;

`ifdef PC_CALL_STACK_EN
  localparam int SPW = $clog2(STACK_DEPTH + 1);

  logic           err_q, err_d;
  logic [SPW-1:0] sp_q, sp_d;
  logic [7:0]     stk_q [STACK_DEPTH];
  logic [7:0]     stk_d [STACK_DEPTH];
  logic           full, empty;

  assign full  = (sp_q == SPW'(STACK_DEPTH));
  assign empty = (sp_q == '0);
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ic_d    = ic_q;
    halt_x  = 1'b0;
    br      = 1'b0;
    off     = 8'h00;
`ifdef PC_CALL_STACK_EN
    err_d   = err_q;
    sp_d    = sp_q;
    stk_d   = stk_q;
`endif
    unique case (state_q)
      IDLE: begin
        ic_d = '0;
`ifdef PC_CALL_STACK_EN
        err_d = 1'b0;
        sp_d  = '0;
`endif
        if (bus.start) begin
          state_d = FETCH;
          cnt_d   = LOAD;
        end
      end
      FETCH: begin
        if (cnt_q == '0) state_d = EXEC;
        else             cnt_d   = cnt_q - CW'(1);
      end
      EXEC: begin
        ic_d    = (&ic_q) ? ic_q : ic_q + 16'd1;
        state_d = FETCH;
        cnt_d   = LOAD;
        // Decoder priority: halt > ret > call > branch
        if (bus.is_halt) begin
          halt_x  = 1'b1;
          state_d = HALTED;
`ifdef PC_CALL_STACK_EN
        end else if (bus.is_ret) begin
          if (empty) begin
            halt_x  = 1'b1;
            err_d   = 1'b1;
            state_d = HALTED;
          end else begin
            br   = 1'b1;
            off  = stk_q[0] - bus.pc_addr;
            sp_d = sp_q - SPW'(1);
            for (int i = 0; i < STACK_DEPTH - 1; i++)
              stk_d[i] = stk_q[i+1];
          end
        end else if (bus.is_call) begin
          if (full) begin
            halt_x  = 1'b1;
            err_d   = 1'b1;
            state_d = HALTED;
          end else begin
            br   = 1'b1;
            off  = bus.br_offset;
            sp_d = sp_q + SPW'(1);
            for (int i = STACK_DEPTH - 1; i > 0; i--)
              stk_d[i] = stk_q[i-1];
            stk_d[0] = bus.pc_addr + 8'd1;
          end
`endif
        end else if (bus.is_branch && bus.cond_flag) begin
          br  = 1'b1;
          off = bus.br_offset;
        end
      end
      HALTED: begin
        if (bus.start) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ic_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ic_q    <= ic_d;
    end
  end

`ifdef PC_CALL_STACK_EN
  // Shift-register LIFO: entry 0 is always the top of stack
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_q <= 1'b0;
      sp_q  <= '0;
      for (int i = 0; i < STACK_DEPTH; i++)
        stk_q[i] <= 8'h00;
    end else begin
      err_q <= err_d;
      sp_q  <= sp_d;
      stk_q <= stk_d;
    end
  end

  assign bus.err = err_q;
`else
  assign bus.err = 1'b0;
`endif

  assign bus.pc_reset  = (state_q == IDLE);
  assign bus.pc_halt   = (state_q != EXEC) || halt_x;
  assign bus.pc_branch = br;
  assign bus.pc_offset = off;
  assign bus.state     = state_q;
  assign bus.done      = (state_q == HALTED);
  assign bus.icount    = ic_q;

endmodule
